// File: rtl/pattern_gen.sv
// Test-pattern pixel generator: fill, blinking crosshair, blinking box or
// fixed color, with a frame-synchronous movable cursor.
module pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW = 3,
  parameter int THICK = 2,
  parameter int BOX_HALF = 10,
  parameter int STEP = 8,
  parameter int BLINK_FRAMES = 30,
  parameter logic [CW-1:0] FIXED = CW'(3'b101)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [9:0]    hcnt,
  input  logic [9:0]    vcnt,
  input  logic [CW-1:0] color,
  input  logic          mv_up,
  input  logic          mv_dn,
  input  logic          mv_lt,
  input  logic          mv_rt,
  output logic [CW-1:0] color_out,
  output logic          frame_start
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] CNT_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [9:0] CX0 = 10'(H_ACTIVE / 2);
  localparam logic [9:0] CY0 = 10'(V_ACTIVE / 2);

  typedef enum logic [1:0] {
    M_FILL,
    M_CROSS,
    M_BOX,
    M_FIXED
  } mode_t;

  mode_t         mode_q, mode_n;
  logic [9:0]    cx, cy, cx_n, cy_n;
  logic [FW-1:0] frame_cnt, cnt_n;
  logic          blink, blink_n;
  logic [3:0]    pend, eff;
  logic          fs, active, hit_x, hit_y, in_box;
  logic [CW-1:0] pix;
  int            h, v, x, y;

  // Opposing requests cancel; the result is clamped, never wrapped.
  function automatic logic [9:0] nudge(
    input logic [9:0] pos,
    input logic       dec,
    input logic       inc,
    input int         lim
  );
    int t;
    t = int'(pos);
    if (dec && !inc) t = t - STEP;
    if (inc && !dec) t = t + STEP;
    if (t < 0) t = 0;
    if (t > lim) t = lim;
    return t[9:0];
  endfunction

  always_comb begin
    fs = (hcnt == 10'd0) && (vcnt == 10'd0);
    eff = pend | {mv_up, mv_dn, mv_lt, mv_rt};
    mode_n = mode_q;
    cx_n = cx;
    cy_n = cy;
    cnt_n = frame_cnt;
    blink_n = blink;
    if (fs) begin
      mode_n = mode_t'(mode);
      cx_n = nudge(cx, eff[1], eff[0], H_ACTIVE - 1);
      cy_n = nudge(cy, eff[3], eff[2], V_ACTIVE - 1);
      if (frame_cnt == CNT_LAST) begin
        cnt_n = '0;
        blink_n = ~blink;
      end else begin
        cnt_n = frame_cnt + FW'(1);
      end
    end
  end

  // Pixel uses next-state cursor/mode so the frame-start pixel is current.
  always_comb begin
    h = int'(hcnt);
    v = int'(vcnt);
    x = int'(cx_n);
    y = int'(cy_n);
    active = (h < H_ACTIVE) && (v < V_ACTIVE);
    hit_x = (h >= x) && (h <= x + THICK - 1)
         && (h <= H_ACTIVE - 1);
    hit_y = (v >= y) && (v <= y + THICK - 1)
         && (v <= V_ACTIVE - 1);
    in_box = (h >= x - BOX_HALF) && (h <= x + BOX_HALF)
          && (v >= y - BOX_HALF) && (v <= y + BOX_HALF);
    pix = color;
    unique case (mode_n)
      M_FILL:  pix = color;
      M_CROSS: pix = (hit_x || hit_y) ? color : ~color;
      M_BOX:   pix = in_box ? color : ~color;
      M_FIXED: pix = FIXED;
    endcase
    if (blink_n && (mode_n == M_CROSS || mode_n == M_BOX))
      pix = ~color;
    if (!active) pix = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= M_FILL;
      cx <= CX0;
      cy <= CY0;
      frame_cnt <= '0;
      blink <= 1'b0;
      pend <= 4'b0;
      color_out <= '0;
      frame_start <= 1'b0;
    end else begin
      mode_q <= mode_n;
      cx <= cx_n;
      cy <= cy_n;
      frame_cnt <= cnt_n;
      blink <= blink_n;
      pend <= fs ? 4'b0 : eff;
      color_out <= pix;
      frame_start <= fs;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: two instances (blink period 30 and 2) checked
// against a frame-level reference model.
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [9:0] hcnt, vcnt;
  logic [2:0] color;
  logic       mv_up, mv_dn, mv_lt, mv_rt;
  logic [2:0] color_out, color_out2;
  logic       frame_start, frame_start2;

  int ncmp = 0;
  int nfail = 0;

  // Reference state; frame index 0 is the frame in progress at reset.
  int       m_mode, m_cx, m_cy, m_frames;
  bit [3:0] m_pend;
  logic [2:0] e_col, e_col2;
  logic       e_fs;

  pattern_gen dut (
    .clk(clk), .rst(rst), .mode(mode),
    .hcnt(hcnt), .vcnt(vcnt), .color(color),
    .mv_up(mv_up), .mv_dn(mv_dn),
    .mv_lt(mv_lt), .mv_rt(mv_rt),
    .color_out(color_out),
    .frame_start(frame_start)
  );

  pattern_gen #(.BLINK_FRAMES(2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode),
    .hcnt(hcnt), .vcnt(vcnt), .color(color),
    .mv_up(mv_up), .mv_dn(mv_dn),
    .mv_lt(mv_lt), .mv_rt(mv_rt),
    .color_out(color_out2),
    .frame_start(frame_start2)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int a, int hi);
    if (a < 0) return 0;
    if (a > hi) return hi;
    return a;
  endfunction

  function automatic logic [2:0] ref_pix(
    int h, int v, logic [2:0] c,
    int md, int x, int y, int bl
  );
    bit hit;
    if (!(h < 640 && v < 480)) return 3'b000;
    if (bl != 0 && (md == 1 || md == 2)) return ~c;
    hit = 1'b0;
    case (md)
      0: return c;
      1: hit = (h >= x && h < x + 2) || (v >= y && v < y + 2);
      2: hit = h >= x - 10 && h <= x + 10
            && v >= y - 10 && v <= y + 10;
      default: return 3'b101;
    endcase
    return hit ? c : ~c;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cx = 320;
    m_cy = 240;
    m_frames = 0;
    m_pend = 4'b0;
    e_col = 3'b0;
    e_col2 = 3'b0;
    e_fs = 1'b0;
  endtask

  // mv = {up, dn, lt, rt}; drives one pixel clock and updates the model.
  task automatic step(
    input int h, input int v, input logic [2:0] c,
    input int md, input logic [3:0] mv
  );
    bit [3:0] eff;
    hcnt = 10'(h);
    vcnt = 10'(v);
    color = c;
    mode = 2'(md);
    {mv_up, mv_dn, mv_lt, mv_rt} = mv;
    @(posedge clk);
    if (!rst) begin
      if (h == 0 && v == 0) begin
        eff = m_pend | mv;
        m_cx = clampi(m_cx + (eff[0] ? 8 : 0)
                      - (eff[1] ? 8 : 0), 639);
        m_cy = clampi(m_cy + (eff[2] ? 8 : 0)
                      - (eff[3] ? 8 : 0), 479);
        m_mode = md;
        m_frames++;
        m_pend = 4'b0;
      end else begin
        m_pend |= mv;
      end
      e_col = ref_pix(h, v, c, m_mode, m_cx, m_cy,
                      (m_frames / 30) % 2);
      e_col2 = ref_pix(h, v, c, m_mode, m_cx, m_cy,
                       (m_frames / 2) % 2);
      e_fs = (h == 0 && v == 0);
    end
    #1;
    {mv_up, mv_dn, mv_lt, mv_rt} = 4'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hcnt = 10'd5;
    vcnt = 10'd5;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Insert empty frames until frame (m_frames+ahead) is visible for dut.
  task automatic pad(input int md, input logic [2:0] c, input int ahead);
    while (((m_frames + ahead) / 30) % 2 != 0)
      step(0, 0, c, md, 4'b0);
  endtask

  task automatic rand_hv(output int h, output int v);
    h = $urandom_range(0, 719);
    v = $urandom_range(0, 519);
    if (h == 0 && v == 0) h = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 2'd3;
    hcnt = 10'd5;
    vcnt = 10'd5;
    color = 3'b111;
    {mv_up, mv_dn, mv_lt, mv_rt} = 4'b0;
    model_reset();
    #3;
    if (color_out !== 3'b000 || color_out2 !== 3'b000) begin
      nfail++;
      $display("FAIL reset_color got=%b/%b want=000",
               color_out, color_out2);
    end
    ncmp++;
    if (frame_start !== 1'b0 || frame_start2 !== 1'b0) begin
      nfail++;
      $display("FAIL reset_fs got=%b/%b want=0",
               frame_start, frame_start2);
    end
    ncmp++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_crosshair();
    int h, v;
    logic [2:0] c;
    do_reset();
    step(0, 0, 3'b010, 1, 4'b0);
    if (frame_start !== 1'b1 || color_out !== 3'b101) begin
      nfail++;
      $display("FAIL xh_origin got fs=%b col=%b want fs=1 col=101",
               frame_start, color_out);
    end
    ncmp++;
    step(320, 100, 3'b010, 1, 4'b0);
    if (color_out !== 3'b010 || frame_start !== 1'b0) begin
      nfail++;
      $display("FAIL xh_on got col=%b fs=%b want 010 fs=0",
               color_out, frame_start);
    end
    ncmp++;
    step(100, 100, 3'b010, 1, 4'b0);
    if (color_out !== 3'b101) begin
      nfail++;
      $display("FAIL xh_off got=%b want=101", color_out);
    end
    ncmp++;
    for (int i = 0; i < 40; i++) begin
      rand_hv(h, v);
      c = 3'($urandom);
      step(h, v, c, $urandom_range(0, 3), 4'b0);
      if (color_out !== e_col || frame_start !== e_fs) begin
        nfail++;
        $display("FAIL xh_rand h=%0d v=%0d got=%b want=%b",
                 h, v, color_out, e_col);
      end
      ncmp++;
    end
  endtask

  task automatic test_mode_change();
    do_reset();
    step(0, 0, 3'b010, 1, 4'b0);
    step(200, 200, 3'b010, 2, 4'b0);
    if (color_out !== 3'b101) begin
      nfail++;
      $display("FAIL mc_mid got=%b want=101", color_out);
    end
    ncmp++;
    step(310, 230, 3'b010, 2, 4'b0);
    if (color_out !== 3'b101) begin
      nfail++;
      $display("FAIL mc_still_xh got=%b want=101", color_out);
    end
    ncmp++;
    step(0, 0, 3'b010, 2, 4'b0);
    step(310, 230, 3'b010, 2, 4'b0);
    if (color_out !== 3'b010) begin
      nfail++;
      $display("FAIL mc_box got=%b want=010", color_out);
    end
    ncmp++;
    if (color_out2 !== e_col2) begin
      nfail++;
      $display("FAIL mc_box_blink2 got=%b want=%b",
               color_out2, e_col2);
    end
    ncmp++;
  endtask

  task automatic test_clamp();
    int h, v;
    logic [2:0] c;
    do_reset();
    c = 3'b011;
    step(0, 0, c, 1, 4'b0);
    for (int i = 0; i < 120; i++) begin
      rand_hv(h, v);
      step(h, v, c, 1, 4'b0010);
      if (color_out !== e_col || color_out2 !== e_col2) begin
        nfail++;
        $display("FAIL cl_mid h=%0d v=%0d got=%b/%b want=%b/%b",
                 h, v, color_out, color_out2, e_col, e_col2);
      end
      ncmp++;
      step(0, 0, c, 1, 4'b0);
      step(m_cx, 300, c, 1, 4'b0);
      if (color_out !== e_col || color_out2 !== e_col2) begin
        nfail++;
        $display("FAIL cl_cur cx=%0d got=%b/%b want=%b/%b",
                 m_cx, color_out, color_out2, e_col, e_col2);
      end
      ncmp++;
    end
    pad(1, c, 0);
    for (int hh = 0; hh < 4; hh++) begin
      step(hh, 100, c, 1, 4'b0);
      if (color_out !== ((hh < 2) ? c : ~c)) begin
        nfail++;
        $display("FAIL cl_zero h=%0d got=%b want=%b",
                 hh, color_out, (hh < 2) ? c : ~c);
      end
      ncmp++;
    end
    pad(1, c, 1);
    step(50, 50, c, 1, 4'b1000);
    step(0, 0, c, 1, 4'b0100);
    step(100, 240, c, 1, 4'b0);
    if (color_out !== c) begin
      nfail++;
      $display("FAIL cl_updn_row got=%b want=%b", color_out, c);
    end
    ncmp++;
    step(100, 232, c, 1, 4'b0);
    if (color_out !== ~c) begin
      nfail++;
      $display("FAIL cl_updn_up got=%b want=%b", color_out, ~c);
    end
    ncmp++;
  endtask

  task automatic test_box_edges();
    int h, v;
    logic [2:0] c, want;
    do_reset();
    c = 3'b110;
    step(0, 0, c, 2, 4'b0);
    for (int i = 0; i < 40; i++) begin
      step(7, 9, c, 2, 4'b0101);
      step(0, 0, c, 2, 4'b0);
    end
    for (int i = 0; i < 79; i++) begin
      step(7, 9, c, 2, (i < 59) ? 4'b1010 : 4'b0010);
      step(0, 0, c, 2, 4'b0);
    end
    pad(2, c, 0);
    for (int yy = 0; yy <= 20; yy++) begin
      for (int xx = 0; xx <= 20; xx++) begin
        if (xx == 0 && yy == 0) continue;
        step(xx, yy, c, 2, 4'b0);
        want = (xx <= 17 && yy <= 17) ? c : ~c;
        if (color_out !== want || color_out2 !== e_col2) begin
          nfail++;
          $display("FAIL box7 h=%0d v=%0d got=%b/%b want=%b/%b",
                   xx, yy, color_out, color_out2, want, e_col2);
        end
        ncmp++;
      end
    end
    step(3, 3, c, 2, 4'b1010);
    step(0, 0, c, 2, 4'b0);
    pad(2, c, 0);
    for (int xx = 1; xx <= 12; xx++) begin
      v = (xx % 4) * 4;
      step(xx, v, c, 2, 4'b0);
      want = (xx <= 10 && v <= 10) ? c : ~c;
      if (color_out !== want) begin
        nfail++;
        $display("FAIL box0 h=%0d v=%0d got=%b want=%b",
                 xx, v, color_out, want);
      end
      ncmp++;
    end
    for (int i = 0; i < 80; i++) begin
      step(9, 9, c, 2, 4'b0101);
      step(0, 0, c, 2, 4'b0);
    end
    for (int i = 0; i < 40; i++) begin
      h = $urandom_range(615, 719);
      v = $urandom_range(455, 519);
      step(h, v, c, 2, 4'b0);
      if (color_out !== e_col || color_out2 !== e_col2) begin
        nfail++;
        $display("FAIL box_far h=%0d v=%0d got=%b/%b want=%b/%b",
                 h, v, color_out, color_out2, e_col, e_col2);
      end
      ncmp++;
    end
  endtask

  task automatic test_blink();
    logic [2:0] c, want;
    do_reset();
    c = 3'($urandom);
    for (int f = 1; f <= 5; f++) begin
      step(0, 0, c, 1, 4'b0);
      step(320, 10, c, 1, 4'b0);
      want = (f == 2 || f == 3) ? ~c : c;
      if (color_out2 !== want || color_out !== c) begin
        nfail++;
        $display("FAIL blink f=%0d got=%b/%b want=%b/%b",
                 f, color_out2, color_out, want, c);
      end
      ncmp++;
      step(10, 10, c, 1, 4'b0);
      if (color_out2 !== ~c) begin
        nfail++;
        $display("FAIL blink_off f=%0d got=%b want=%b",
                 f, color_out2, ~c);
      end
      ncmp++;
    end
    for (int md = 0; md < 4; md++) begin
      step(0, 0, c, md, 4'b0);
      step(700, $urandom_range(0, 479), c, md, 4'b0);
      if (color_out !== 3'b000 || color_out2 !== 3'b000) begin
        nfail++;
        $display("FAIL h700 mode=%0d got=%b/%b want=000",
                 md, color_out, color_out2);
      end
      ncmp++;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] c;
    do_reset();
    c = 3'b001;
    step(0, 0, c, 3, 4'b0);
    step(5, 5, c, 3, 4'b0001);
    if (color_out !== 3'b101) begin
      nfail++;
      $display("FAIL rm_fixed got=%b want=101", color_out);
    end
    ncmp++;
    rst = 1'b1;
    model_reset();
    #1;
    if (color_out !== 3'b000 || color_out2 !== 3'b000) begin
      nfail++;
      $display("FAIL rm_async got=%b/%b want=000",
               color_out, color_out2);
    end
    ncmp++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(100, 100, c, 3, 4'b0);
    if (color_out !== c) begin
      nfail++;
      $display("FAIL rm_mode0 got=%b want=%b", color_out, c);
    end
    ncmp++;
    step(0, 0, c, 1, 4'b0);
    step(320, 100, c, 1, 4'b0);
    if (color_out !== c) begin
      nfail++;
      $display("FAIL rm_cx320 got=%b want=%b", color_out, c);
    end
    ncmp++;
    step(328, 100, c, 1, 4'b0);
    if (color_out !== ~c) begin
      nfail++;
      $display("FAIL rm_nomove got=%b want=%b", color_out, ~c);
    end
    ncmp++;
  endtask

  initial begin
    test_reset();
    test_crosshair();
    test_mode_change();
    test_clamp();
    test_box_edges();
    test_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
